// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state codes, digit sizing and BCD helper for the keypad controller
package keypad_pkg;
  localparam int NDIG_DEF = 4;
  localparam int BCD_W = 4;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;
  function automatic logic is_bcd(input logic [BCD_W-1:0] v);
    return v <= BCD_W'(9);
  endfunction
endpackage

// File: rtl/keypad_ctrl_if.sv
// keypad_ctrl_if: encoder, button, door/timer and status signals of the keypad controller
interface keypad_ctrl_if
  import keypad_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
);
  logic [BCD_W-1:0] D;
  logic loadn;
  logic startn;
  logic stopn;
  logic door_closed;
  logic zero;
  logic enbn;
  logic [BCD_W*NDIG-1:0] digits;
  logic timer_loadn;
  logic timer_en;
  logic mag_on;
  logic done;
  logic [2:0] state;
  modport ctrl (
    input  D, loadn, startn, stopn, door_closed, zero,
    output enbn, digits, timer_loadn, timer_en, mag_on, done, state
  );
  modport env (
    output D, loadn, startn, stopn, door_closed, zero,
    input  enbn, digits, timer_loadn, timer_en, mag_on, done, state
  );
endinterface

// File: rtl/neg_edge_det.sv
// neg_edge_det: one-cycle event on a 1->0 transition of an active-low strobe
module neg_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);
  logic q;
  logic armed;
  // armed stays low for the first edge after reset so a strobe already low at release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b1;
      armed <= 1'b0;
    end else begin
      q <= sig;
      armed <= 1'b1;
    end
  end
  assign pulse = armed & q & ~sig;
endmodule

// File: rtl/keypad_ctrl.sv
// keypad_ctrl: microwave keypad front end -- BCD time entry, start/stop/pause and cook sequencing
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input logic clk,
  input logic clearn,
  keypad_ctrl_if.ctrl bus
);
  state_t cur, nxt;
  logic [BCD_W*NDIG-1:0] dig, dig_n;
  logic ev_load, ev_start, ev_stop, entry_en, take;
  neg_edge_det u_load  (.clk(clk), .rst_n(clearn), .sig(bus.loadn),  .pulse(ev_load));
  neg_edge_det u_start (.clk(clk), .rst_n(clearn), .sig(bus.startn), .pulse(ev_start));
  neg_edge_det u_stop  (.clk(clk), .rst_n(clearn), .sig(bus.stopn),  .pulse(ev_stop));
  assign entry_en = cur == IDLE || cur == ENTRY;
  assign take = ev_load && entry_en && is_bcd(bus.D);
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      cur <= IDLE;
      dig <= '0;
    end else begin
      cur <= nxt;
      dig <= dig_n;
    end
  end
  always_comb begin
    nxt = IDLE;
    case (cur)
      IDLE:  nxt = take ? ENTRY : IDLE;
      ENTRY: nxt = ev_stop ? IDLE : (ev_start && bus.door_closed && dig != '0) ? LOAD : ENTRY;
      LOAD:  nxt = COOK;
      COOK:  nxt = bus.zero ? DONE : (ev_stop || !bus.door_closed) ? PAUSE : COOK;
      PAUSE: nxt = ev_stop ? IDLE : (ev_start && bus.door_closed) ? COOK : PAUSE;
      DONE:  nxt = (ev_stop || !bus.door_closed) ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    // every arrival in IDLE wipes the entered time; otherwise shift the new digit in at the LSD
    dig_n = nxt == IDLE ? '0 : take ? {dig[BCD_W*(NDIG-1)-1:0], bus.D} : dig;
  end
  assign bus.enbn = !entry_en;
  assign bus.digits = dig;
  assign bus.timer_loadn = cur != LOAD;
  assign bus.timer_en = cur == COOK;
  assign bus.mag_on = cur == COOK;
  assign bus.done = cur == DONE;
  assign bus.state = cur;
endmodule

// File: tb/tb_keypad_ctrl.sv
// tb_keypad_ctrl: directed and random stimulus against a queue-based reference scoreboard
module tb_keypad_ctrl;
  localparam int NDIG = 4;
  typedef struct {
    string name;
    logic [23:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic clearn = 1'b0;
  keypad_ctrl_if #(.NDIG(NDIG)) bus ();
  keypad_ctrl #(.NDIG(NDIG)) dut (.clk(clk), .clearn(clearn), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [3:0] d_s = 4'd0;
  logic ld_s = 1'b1, st_s = 1'b1, sp_s = 1'b1, door_s = 1'b1, zero_s = 1'b0, clr_s = 1'b0;
  int m_st = 0;
  int m_dg[NDIG];
  bit pl = 1'b1, ps = 1'b1, pp = 1'b1, fresh = 1'b0;
  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask
  function automatic int mval();
    int v = 0;
    for (int i = 0; i < NDIG; i++) v = v * 16 + m_dg[i];
    return v;
  endfunction
  function automatic logic [23:0] mvec();
    return {3'(m_st), 16'(mval()), m_st > 1, m_st != 2, m_st == 3, m_st == 3, m_st == 5};
  endfunction
  // reference: time is a list of decimal digits, modes are the spec's numeric codes
  task automatic mstep();
    bit el, es, ep, tk;
    if (!clr_s) begin
      m_st = 0;
      for (int i = 0; i < NDIG; i++) m_dg[i] = 0;
      pl = 1; ps = 1; pp = 1; fresh = 0;
      return;
    end
    el = fresh && pl && !ld_s;
    es = fresh && ps && !st_s;
    ep = fresh && pp && !sp_s;
    tk = el && m_st <= 1 && d_s <= 9;
    case (m_st)
      0: if (tk) m_st = 1;
      1: if (ep) m_st = 0; else if (es && door_s && mval() != 0) m_st = 2;
      2: m_st = 3;
      3: if (zero_s) m_st = 5; else if (ep || !door_s) m_st = 4;
      4: if (ep) m_st = 0; else if (es && door_s) m_st = 3;
      5: if (ep || !door_s) m_st = 0;
      default: m_st = 0;
    endcase
    if (tk) begin
      for (int i = 0; i < NDIG - 1; i++) m_dg[i] = m_dg[i+1];
      m_dg[NDIG-1] = int'(d_s);
    end
    if (m_st == 0) for (int i = 0; i < NDIG; i++) m_dg[i] = 0;
    pl = ld_s; ps = st_s; pp = sp_s; fresh = 1;
  endtask
  task automatic tick(input string nm);
    @(negedge clk);
    bus.D = d_s; bus.loadn = ld_s; bus.startn = st_s; bus.stopn = sp_s;
    bus.door_closed = door_s; bus.zero = zero_s; clearn = clr_s;
    mstep();
    sb.push_back('{name: nm, v: mvec()});
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  task automatic press_digit(input logic [3:0] v);
    d_s = v; ld_s = 0; tick("digit_lo");
    ld_s = 1; tick("digit_hi");
  endtask
  task automatic press_start();
    st_s = 0; tick("start_lo");
    st_s = 1; tick("start_hi");
  endtask
  task automatic press_stop();
    sp_s = 0; tick("stop_lo");
    sp_s = 1; tick("stop_hi");
  endtask
  initial begin
    for (int i = 0; i < NDIG; i++) m_dg[i] = 0;
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        cmp(e.name, 32'({bus.state, bus.digits, bus.enbn, bus.timer_loadn, bus.timer_en, bus.mag_on, bus.done}), 32'(e.v));
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.D = 4'd0; bus.loadn = 1; bus.startn = 1; bus.stopn = 1; bus.door_closed = 1; bus.zero = 0;
    tick("reset0");
    tick("reset1");
    clr_s = 1;
    tick("release");
    press_digit(4'd1);
    press_digit(4'd3);
    press_digit(4'd0);
    settle();
    cmp("entry_digits", 32'(bus.digits), 32'h0130);
    cmp("entry_state", 32'(bus.state), 32'd1);
    cmp("entry_enbn", 32'(bus.enbn), 32'd0);
    st_s = 0; tick("start_load");
    settle();
    cmp("load_tl", 32'(bus.timer_loadn), 32'd0);
    cmp("load_state", 32'(bus.state), 32'd2);
    st_s = 1; tick("load_cook");
    settle();
    cmp("cook_state", 32'(bus.state), 32'd3);
    cmp("cook_mag", 32'(bus.mag_on), 32'd1);
    cmp("cook_enbn", 32'(bus.enbn), 32'd1);
    cmp("cook_tl", 32'(bus.timer_loadn), 32'd1);
    door_s = 0; tick("door_open");
    settle();
    cmp("pause_state", 32'(bus.state), 32'd4);
    cmp("pause_mag", 32'(bus.mag_on), 32'd0);
    door_s = 1; tick("door_shut");
    press_start();
    settle();
    cmp("resume_state", 32'(bus.state), 32'd3);
    cmp("resume_tl", 32'(bus.timer_loadn), 32'd1);
    zero_s = 1; sp_s = 0; tick("zero_and_stop");
    settle();
    cmp("done_state", 32'(bus.state), 32'd5);
    cmp("done_flag", 32'(bus.done), 32'd1);
    zero_s = 0; sp_s = 1; tick("done_hold");
    press_stop();
    settle();
    cmp("idle_state", 32'(bus.state), 32'd0);
    cmp("idle_digits", 32'(bus.digits), 32'd0);
    for (int i = 1; i <= 5; i++) press_digit(4'(i));
    settle();
    cmp("wrap_digits", 32'(bus.digits), 32'h2345);
    press_digit(4'hA);
    settle();
    cmp("nonbcd_digits", 32'(bus.digits), 32'h2345);
    press_stop();
    press_digit(4'd5);
    press_start();
    settle();
    cmp("pre_rst_mag", 32'(bus.mag_on), 32'd1);
    #1;
    clr_s = 0;
    clearn = 0;
    #1;
    cmp("async_rst_mag", 32'(bus.mag_on), 32'd0);
    cmp("async_rst_state", 32'(bus.state), 32'd0);
    cmp("async_rst_digits", 32'(bus.digits), 32'd0);
    st_s = 0; ld_s = 0; d_s = 4'd7;
    tick("rst_hold0");
    tick("rst_hold1");
    clr_s = 1;
    tick("rst_release");
    tick("held_low");
    settle();
    cmp("held_low_state", 32'(bus.state), 32'd0);
    cmp("held_low_digits", 32'(bus.digits), 32'd0);
    ld_s = 1; tick("ld_up");
    press_digit(4'd4);
    tick("start_still_low");
    settle();
    cmp("no_start_state", 32'(bus.state), 32'd1);
    cmp("no_start_digits", 32'(bus.digits), 32'h0004);
    st_s = 1; tick("st_up");
    press_start();
    press_stop();
    press_stop();
    for (int n = 0; n < 600; n++) begin
      d_s = 4'($urandom_range(0, 15));
      ld_s = $urandom_range(0, 2) != 0;
      st_s = $urandom_range(0, 2) != 0;
      sp_s = $urandom_range(0, 5) != 0;
      door_s = $urandom_range(0, 7) != 0;
      zero_s = $urandom_range(0, 9) == 0;
      clr_s = $urandom_range(0, 99) != 0;
      tick("rand");
    end
    clr_s = 1; ld_s = 1; st_s = 1; sp_s = 1;
    tick("tail");
    settle();
    cmp("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
